// File: rtl/stream_cmp_pkg.sv
// Shared types and defaults for the stream compare controller.
//   state_e  : controller FSM states
//   DefDw    : default data word width of both streams
//   DefLenW  : default width of length, index and mismatch-count fields
package stream_cmp_pkg;

    localparam int unsigned DefDw   = 4;
    localparam int unsigned DefLenW = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/stream_cmp_ctrl_if.sv
// Joint A/B stream bundle feeding the compare controller.
//   a_vld/a_data/a_rdy : stream A valid, word, accept
//   b_vld/b_data/b_rdy : stream B valid, word, accept
//   master : producer side (drives valid/data, sees ready)
//   slave  : controller side (sees valid/data, drives ready)
interface stream_cmp_ctrl_if
    import stream_cmp_pkg::*;
#(
    parameter int unsigned DW = DefDw
);

    logic          a_vld;
    logic [DW-1:0] a_data;
    logic          a_rdy;
    logic          b_vld;
    logic [DW-1:0] b_data;
    logic          b_rdy;

    modport master (
        output a_vld, a_data, b_vld, b_data,
        input  a_rdy, b_rdy
    );

    modport slave (
        input  a_vld, a_data, b_vld, b_data,
        output a_rdy, b_rdy
    );

endinterface

// File: rtl/word_eq_cmp.sv
// Shared word comparator.
//   a, b    : words to compare
//   eq_log  : logical equality (X when either side carries X/Z in a deciding bit)
//   eq_case : case equality (exact 4-state match, never X)
module word_eq_cmp
    import stream_cmp_pkg::*;
#(
    parameter int unsigned DW = DefDw
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          eq_log,
    output logic          eq_case
);

    assign eq_log  = (a == b);
    assign eq_case = (a === b);

endmodule

// File: rtl/stream_cmp_ctrl.sv
// Compare controller: after start, consumes len word pairs from streams A and B
// through one shared comparator, counting mismatches, recording the first
// mismatching index and flagging X/Z contamination.
//   clk, rst             : clock, synchronous active-high reset
//   start, len           : launch a run of len pairs (sampled in IDLE only)
//   abort                : end the current run early (RUN only)
//   strm                 : A/B valid/data in, joint ready out
//   busy, done, pass     : run in progress, one-cycle finish pulse, clean result
//   mis_cnt              : saturating mismatch count
//   first_idx, first_vld : index of the first mismatch and its valid flag
//   xz_seen              : some accepted pair compared as X
module stream_cmp_ctrl
    import stream_cmp_pkg::*;
#(
    parameter int unsigned DW    = DefDw,
    parameter int unsigned LEN_W = DefLenW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    stream_cmp_ctrl_if.slave strm,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [LEN_W-1:0] mis_cnt,
    output logic [LEN_W-1:0] first_idx,
    output logic             first_vld,
    output logic             xz_seen
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] mis_cnt_q, mis_cnt_d;
    logic [LEN_W-1:0] first_idx_q, first_idx_d;
    logic             first_vld_q, first_vld_d;
    logic             xz_seen_q, xz_seen_d;
    logic             pass_q, pass_d;

    logic             eq_log;
    logic             eq_case;
    logic             accept;
    logic             mismatch;
    logic             xz_hit;
    logic [LEN_W-1:0] idx_inc;

    word_eq_cmp #(
        .DW (DW)
    ) u_word_eq_cmp (
        .a       (strm.a_data),
        .b       (strm.b_data),
        .eq_log  (eq_log),
        .eq_case (eq_case)
    );

    // Joint handshake: neither stream is consumed unless both are valid.
    assign accept      = (state_q == StRun) && strm.a_vld && strm.b_vld;
    assign strm.a_rdy  = accept;
    assign strm.b_rdy  = accept;

    // An X equality result counts as a mismatch; case inequality keeps the
    // decision 2-valued in 4-state simulation.
    assign mismatch = accept && (eq_log !== 1'b1);
    assign xz_hit   = accept && (eq_log !== eq_case);
    assign idx_inc  = idx_q + LEN_W'(1);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        mis_cnt_d   = mis_cnt_q;
        first_idx_d = first_idx_q;
        first_vld_d = first_vld_q;
        xz_seen_d   = xz_seen_q;
        pass_d      = pass_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d       = len;
                    idx_d       = '0;
                    mis_cnt_d   = '0;
                    first_idx_d = '0;
                    first_vld_d = 1'b0;
                    xz_seen_d   = 1'b0;
                    if (len == '0) begin
                        // Empty run finishes clean with no pairs consumed.
                        state_d = StDone;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                        pass_d  = 1'b0;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    if (mismatch) begin
                        if (mis_cnt_q != '1) begin
                            mis_cnt_d = mis_cnt_q + LEN_W'(1);
                        end
                        if (!first_vld_q) begin
                            first_idx_d = idx_q;
                            first_vld_d = 1'b1;
                        end
                    end
                    if (xz_hit) begin
                        xz_seen_d = 1'b1;
                    end
                    idx_d = idx_inc;
                    if (idx_inc == len_q) begin
                        state_d = StDone;
                    end
                end
                if (abort) begin
                    state_d = StDone;
                end
                // Result is settled on entry to DONE so it shows with the done pulse.
                if (state_d == StDone) begin
                    pass_d = (mis_cnt_d == '0) && !abort;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            idx_q       <= '0;
            mis_cnt_q   <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
            xz_seen_q   <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            mis_cnt_q   <= mis_cnt_d;
            first_idx_q <= first_idx_d;
            first_vld_q <= first_vld_d;
            xz_seen_q   <= xz_seen_d;
            pass_q      <= pass_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign mis_cnt   = mis_cnt_q;
    assign first_idx = first_idx_q;
    assign first_vld = first_vld_q;
    assign xz_seen   = xz_seen_q;

endmodule

// File: tb/tb_stream_cmp_ctrl.sv
// Self-checking bench for stream_cmp_ctrl: table-driven full-throughput runs
// plus hand-written sequences for stalls, X data, empty runs, abort and reset.
module tb_stream_cmp_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       abort;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] mis_cnt;
    logic [7:0] first_idx;
    logic       first_vld;
    logic       xz_seen;

    int n_pass;
    int n_total;

    stream_cmp_ctrl_if #(.DW(4)) strm_if ();

    stream_cmp_ctrl #(
        .DW    (4),
        .LEN_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .strm      (strm_if.slave),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .mis_cnt   (mis_cnt),
        .first_idx (first_idx),
        .first_vld (first_vld),
        .xz_seen   (xz_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned len;
        logic [31:0] a_pat;   // nibble k%8 is the word for pair k
        logic [31:0] b_pat;
        logic [7:0]  exp_mis;
        logic [7:0]  exp_first;
        logic        exp_fvld;
        logic        exp_pass;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_pair(input logic av, input logic [3:0] ad, input logic bv,
                            input logic [3:0] bd);
        strm_if.a_vld  = av;
        strm_if.a_data = ad;
        strm_if.b_vld  = bv;
        strm_if.b_data = bd;
    endtask

    task automatic launch(input logic [7:0] l);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full-throughput run: one pair per cycle, done expected one cycle after the last.
    task automatic run_vec(input vec_t v);
        launch(8'(v.len));
        chk("busy_after_start", 32'(busy), 32'(1));
        for (int k = 0; k < int'(v.len); k++) begin
            set_pair(1'b1, v.a_pat[4*(k%8) +: 4], 1'b1, v.b_pat[4*(k%8) +: 4]);
            #1;
            chk("a_rdy_run", 32'(strm_if.a_rdy), 32'(1));
            chk("done_early", 32'(done), 32'(0));
            @(negedge clk);
        end
        set_pair(1'b0, 4'h0, 1'b0, 4'h0);
        chk("done_pulse", 32'(done), 32'(1));
        chk("busy_in_done", 32'(busy), 32'(0));
        chk("mis_cnt", 32'(mis_cnt), 32'(v.exp_mis));
        chk("first_vld", 32'(first_vld), 32'(v.exp_fvld));
        if (v.exp_fvld) chk("first_idx", 32'(first_idx), 32'(v.exp_first));
        chk("pass", 32'(pass), 32'(v.exp_pass));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'(0));
        chk("pass_hold", 32'(pass), 32'(v.exp_pass));
        chk("mis_cnt_hold", 32'(mis_cnt), 32'(v.exp_mis));
    endtask

    logic [3:0] ax;
    logic [3:0] bx;
    logic       exp_m0;
    logic       exp_xz;
    logic       bpat[4];
    int         acc;

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        start   = 1'b0;
        len     = 8'd0;
        abort   = 1'b0;
        set_pair(1'b0, 4'h0, 1'b0, 4'h0);

        vecs[0] = '{len: 4, a_pat: 32'h0000_FA73, b_pat: 32'h0000_FA73,
                    exp_mis: 8'd0, exp_first: 8'd0, exp_fvld: 1'b0, exp_pass: 1'b1};
        vecs[1] = '{len: 5, a_pat: 32'h000E_C951, b_pat: 32'h000E_D941,
                    exp_mis: 8'd2, exp_first: 8'd1, exp_fvld: 1'b1, exp_pass: 1'b0};
        vecs[2] = '{len: 1, a_pat: 32'h0000_0006, b_pat: 32'h0000_0009,
                    exp_mis: 8'd1, exp_first: 8'd0, exp_fvld: 1'b1, exp_pass: 1'b0};
        vecs[3] = '{len: 8, a_pat: 32'h8765_4321, b_pat: 32'h8765_4321,
                    exp_mis: 8'd0, exp_first: 8'd0, exp_fvld: 1'b0, exp_pass: 1'b1};
        vecs[4] = '{len: 255, a_pat: 32'h0000_0000, b_pat: 32'hFFFF_FFFF,
                    exp_mis: 8'd255, exp_first: 8'd0, exp_fvld: 1'b1, exp_pass: 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_pass", 32'(pass), 32'(0));
        chk("rst_mis_cnt", 32'(mis_cnt), 32'(0));
        chk("rst_first_vld", 32'(first_vld), 32'(0));
        chk("rst_xz", 32'(xz_seen), 32'(0));
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // len=3 with b_vld stalling: ready follows the joint valid only
        bpat = '{1'b1, 1'b0, 1'b1, 1'b1};
        launch(8'd3);
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            set_pair(1'b1, 4'(acc + 2), bpat[c], 4'(acc + 2));
            #1;
            chk("stall_a_rdy", 32'(strm_if.a_rdy), 32'(bpat[c]));
            chk("stall_b_rdy", 32'(strm_if.b_rdy), 32'(bpat[c]));
            if (bpat[c]) acc++;
            @(negedge clk);
        end
        set_pair(1'b0, 4'h0, 1'b0, 4'h0);
        chk("stall_done", 32'(done), 32'(1));
        chk("stall_mis_cnt", 32'(mis_cnt), 32'(0));
        chk("stall_pass", 32'(pass), 32'(1));

        // len=2 with an X-contaminated word in pair 0
        ax     = 4'b10x1;
        bx     = 4'b1011;
        exp_m0 = ((ax == bx) !== 1'b1);
        exp_xz = ((ax == bx) !== (ax === bx));
        launch(8'd2);
        set_pair(1'b1, ax, 1'b1, bx);
        @(negedge clk);
        set_pair(1'b1, 4'h5, 1'b1, 4'h5);
        @(negedge clk);
        set_pair(1'b0, 4'h0, 1'b0, 4'h0);
        chk("x_done", 32'(done), 32'(1));
        chk("x_mis_cnt", 32'(mis_cnt), 32'(exp_m0));
        chk("x_first_vld", 32'(first_vld), 32'(exp_m0));
        chk("x_first_idx", 32'(first_idx), 32'(0));
        chk("x_xz_seen", 32'(xz_seen), 32'(exp_xz));
        chk("x_pass", 32'(pass), 32'(!exp_m0));
        @(negedge clk);

        // len=0: done next cycle, streams never accepted
        @(negedge clk);
        start = 1'b1;
        len   = 8'd0;
        set_pair(1'b1, 4'h1, 1'b1, 4'h2);
        #1;
        chk("len0_rdy_idle", 32'(strm_if.a_rdy), 32'(0));
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", 32'(done), 32'(1));
        chk("len0_pass", 32'(pass), 32'(1));
        chk("len0_rdy_done", 32'(strm_if.a_rdy), 32'(0));
        chk("len0_mis_cnt", 32'(mis_cnt), 32'(0));
        @(negedge clk);
        chk("len0_done_clear", 32'(done), 32'(0));
        chk("len0_rdy_after", 32'(strm_if.b_rdy), 32'(0));
        set_pair(1'b0, 4'h0, 1'b0, 4'h0);

        // len=6 aborted on the 3rd accept, which is itself a mismatch
        launch(8'd6);
        set_pair(1'b1, 4'h3, 1'b1, 4'h3);
        @(negedge clk);
        set_pair(1'b1, 4'h4, 1'b1, 4'h4);
        @(negedge clk);
        set_pair(1'b1, 4'h7, 1'b1, 4'h6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        set_pair(1'b0, 4'h0, 1'b0, 4'h0);
        chk("abort_done", 32'(done), 32'(1));
        chk("abort_mis_cnt", 32'(mis_cnt), 32'(1));
        chk("abort_first_idx", 32'(first_idx), 32'(2));
        chk("abort_pass", 32'(pass), 32'(0));
        // start during DONE must be ignored
        start = 1'b1;
        len   = 8'd5;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_ignored_busy", 32'(busy), 32'(0));
        chk("done_start_ignored_done", 32'(done), 32'(0));
        chk("abort_mis_hold", 32'(mis_cnt), 32'(1));
        @(negedge clk);
        chk("still_idle", 32'(busy), 32'(0));

        // len=6 with all-matching pairs aborted mid-run must still report fail
        launch(8'd6);
        set_pair(1'b1, 4'h9, 1'b1, 4'h9);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        set_pair(1'b0, 4'h0, 1'b0, 4'h0);
        chk("abort_clean_done", 32'(done), 32'(1));
        chk("abort_clean_pass", 32'(pass), 32'(0));
        chk("abort_clean_mis", 32'(mis_cnt), 32'(0));
        @(negedge clk);

        // len=6 with reset after 3 accepts: no done, everything cleared
        launch(8'd6);
        set_pair(1'b1, 4'h1, 1'b1, 4'h1);
        @(negedge clk);
        set_pair(1'b1, 4'h2, 1'b1, 4'h3);
        @(negedge clk);
        set_pair(1'b1, 4'h4, 1'b1, 4'h4);
        @(negedge clk);
        chk("pre_rst_mis_cnt", 32'(mis_cnt), 32'(1));
        chk("pre_rst_busy", 32'(busy), 32'(1));
        set_pair(1'b1, 4'h5, 1'b1, 4'h6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_mis_cnt", 32'(mis_cnt), 32'(0));
        chk("mid_rst_first_vld", 32'(first_vld), 32'(0));
        chk("mid_rst_first_idx", 32'(first_idx), 32'(0));
        chk("mid_rst_a_rdy", 32'(strm_if.a_rdy), 32'(0));
        chk("mid_rst_pass", 32'(pass), 32'(0));
        @(negedge clk);
        chk("post_rst_no_done", 32'(done), 32'(0));
        chk("post_rst_idle", 32'(busy), 32'(0));
        set_pair(1'b0, 4'h0, 1'b0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
